// File: rtl/output_layer_pkg.sv
// output_layer_pkg: AXI write constants, DDR3 row/layer address shifts and writer FSM encoding
package output_layer_pkg;
    localparam logic [2:0] AWSIZE_8B = 3'd3;
    localparam logic [1:0] BURST_INCR = 2'd1;
    localparam logic [3:0] AWCACHE = 4'b0011;
    localparam int BEATS_PER_ROW = 8;
    localparam int ROW_SHIFT = 6;
    localparam int LAYER_SHIFT = 12;
    typedef enum logic [1:0] {IDLE, AW, W, B} wr_state_t;
endpackage

// File: rtl/row_pack_buffer.sv
// row_pack_buffer: two 64-byte ping-pong row buffers; byte-lane write port (wr_*), beat read port (rd_*), release (rel), full flags and drain tag
module row_pack_buffer
    import output_layer_pkg::*;
#(
    parameter int TAG_WIDTH = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [5:0]           wr_col,
    input  logic [7:0]           wr_byte,
    input  logic                 wr_last,
    input  logic [TAG_WIDTH-1:0] wr_tag,
    input  logic [2:0]           rd_beat,
    output logic [63:0]          rd_data,
    input  logic                 rel,
    output logic                 fill_full,
    output logic                 drain_full,
    output logic [TAG_WIDTH-1:0] drain_tag
);
    logic [63:0] mem [2][BEATS_PER_ROW];
    logic [TAG_WIDTH-1:0] tag [2];
    logic [1:0] full;
    logic fill_ptr;
    logic drain_ptr;
    assign rd_data = mem[drain_ptr][rd_beat];
    assign fill_full = full[fill_ptr];
    assign drain_full = full[drain_ptr];
    assign drain_tag = tag[drain_ptr];
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++)
                for (int j = 0; j < BEATS_PER_ROW; j++)
                    mem[i][j] <= '0;
            tag[0] <= '0;
            tag[1] <= '0;
            full <= '0;
            fill_ptr <= 1'b0;
            drain_ptr <= 1'b0;
        end else begin
            if (wr_en) begin
                mem[fill_ptr][wr_col[5:3]][{wr_col[2:0], 3'b000} +: 8] <= wr_byte;
                if (wr_last) begin
                    full[fill_ptr] <= 1'b1;
                    tag[fill_ptr] <= wr_tag;
                    fill_ptr <= ~fill_ptr;
                end
            end
            if (rel) begin
                for (int j = 0; j < BEATS_PER_ROW; j++)
                    mem[drain_ptr][j] <= '0;
                full[drain_ptr] <= 1'b0;
                drain_ptr <= ~drain_ptr;
            end
        end
    end
endmodule

// File: rtl/output_layer_writer.sv
// output_layer_writer: packs a valid/ready pixel byte stream into 64-byte rows and writes each as an 8-beat AXI4 INCR burst; config/start/done/wr_error control, output_layer_1_* stream, M_axi_* master (read channel tied off)
module output_layer_writer
    import output_layer_pkg::*;
#(
    parameter int C_S_AXI_ID_WIDTH = 3,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 64,
    parameter int C_S_AXI_BURST_LEN = 8,
    parameter int STREAM_DATA_WIDTH = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   axi_address,
    input  logic [9:0]                      no_of_output_layers,
    input  logic [9:0]                      output_layer_row_size,
    input  logic [9:0]                      output_layer_col_size,
    input  logic                            start,
    output logic                            done,
    output logic                            wr_error,
    input  logic [STREAM_DATA_WIDTH-1:0]    output_layer_1_data,
    input  logic                            output_layer_1_valid,
    output logic                            output_layer_1_rdy,
    output logic [C_S_AXI_ID_WIDTH-1:0]     M_axi_awid,
    output logic [C_S_AXI_ADDR_WIDTH-1:0]   M_axi_awaddr,
    output logic [7:0]                      M_axi_awlen,
    output logic [2:0]                      M_axi_awsize,
    output logic [1:0]                      M_axi_awburst,
    output logic                            M_axi_awlock,
    output logic [3:0]                      M_axi_awcache,
    output logic [2:0]                      M_axi_awprot,
    output logic [3:0]                      M_axi_awqos,
    output logic                            M_axi_awvalid,
    input  logic                            M_axi_awready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   M_axi_wdata,
    output logic [C_S_AXI_DATA_WIDTH/8-1:0] M_axi_wstrb,
    output logic                            M_axi_wlast,
    output logic                            M_axi_wvalid,
    input  logic                            M_axi_wready,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     M_axi_bid,
    input  logic [1:0]                      M_axi_bresp,
    input  logic                            M_axi_bvalid,
    output logic                            M_axi_bready,
    output logic [C_S_AXI_ID_WIDTH-1:0]     M_axi_arid,
    output logic [C_S_AXI_ADDR_WIDTH-1:0]   M_axi_araddr,
    output logic [7:0]                      M_axi_arlen,
    output logic [2:0]                      M_axi_arsize,
    output logic [1:0]                      M_axi_arburst,
    output logic                            M_axi_arlock,
    output logic [3:0]                      M_axi_arcache,
    output logic [2:0]                      M_axi_arprot,
    output logic [3:0]                      M_axi_arqos,
    output logic                            M_axi_arvalid,
    input  logic                            M_axi_arready,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     M_axi_rid,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   M_axi_rdata,
    input  logic [1:0]                      M_axi_rresp,
    input  logic                            M_axi_rlast,
    input  logic                            M_axi_rvalid,
    output logic                            M_axi_rready
);
    wr_state_t state;
    wr_state_t next_state;
    logic busy;
    logic [C_S_AXI_ADDR_WIDTH-1:0] base;
    logic [9:0] n_lay;
    logic [9:0] n_row;
    logic [9:0] n_col;
    logic [9:0] col;
    logic [9:0] lay;
    logic [9:0] row;
    logic [2:0] beat;
    logic [19:0] drain_tag;
    logic fill_full;
    logic drain_full;
    logic xfer;
    logic col_end;
    logic lay_end;
    logic rel;
    logic last_burst;
    logic unused_ok;
    assign output_layer_1_rdy = busy & ~fill_full;
    assign xfer = output_layer_1_valid & output_layer_1_rdy;
    assign col_end = col == n_col - 10'd1;
    assign lay_end = lay == n_lay - 10'd1;
    assign rel = state == B && M_axi_bvalid;
    assign last_burst = drain_tag == {n_lay - 10'd1, n_row - 10'd1};
    row_pack_buffer #(.TAG_WIDTH(20)) u_buf (
        .clk(clk),
        .reset(reset),
        .wr_en(xfer),
        .wr_col(col[5:0]),
        .wr_byte(output_layer_1_data[7:0]),
        .wr_last(col_end),
        .wr_tag({lay, row}),
        .rd_beat(beat),
        .rd_data(M_axi_wdata),
        .rel(rel),
        .fill_full(fill_full),
        .drain_full(drain_full),
        .drain_tag(drain_tag)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= 1'b0;
            done <= 1'b0;
            wr_error <= 1'b0;
            base <= '0;
            n_lay <= '0;
            n_row <= '0;
            n_col <= '0;
            col <= '0;
            lay <= '0;
            row <= '0;
        end else begin
            done <= rel && last_burst;
            if (start && !busy) begin
                busy <= 1'b1;
                wr_error <= 1'b0;
                base <= axi_address;
                n_lay <= no_of_output_layers;
                n_row <= output_layer_row_size;
                n_col <= output_layer_col_size;
                col <= '0;
                lay <= '0;
                row <= '0;
            end else begin
                if (rel && last_burst) busy <= 1'b0;
                if (rel && |M_axi_bresp) wr_error <= 1'b1;
                if (xfer) begin
                    col <= col_end ? '0 : col + 10'd1;
                    if (col_end) begin
                        lay <= lay_end ? '0 : lay + 10'd1;
                        row <= lay_end ? row + 10'd1 : row;
                    end
                end
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            beat <= '0;
        end else begin
            state <= next_state;
            beat <= (state == W && M_axi_wready) ? beat + 3'd1 : beat;
        end
    end
    always_comb begin
        next_state = state;
        case (state)
            IDLE: next_state = drain_full ? AW : IDLE;
            AW: next_state = M_axi_awready ? W : AW;
            W: next_state = (M_axi_wready && beat == 3'd7) ? B : W;
            default: next_state = M_axi_bvalid ? IDLE : B;
        endcase
    end
    always_comb begin
        M_axi_awvalid = state == AW;
        M_axi_wvalid = state == W;
        M_axi_wlast = state == W && beat == 3'd7;
        M_axi_bready = state == B;
    end
    assign M_axi_awaddr = base + (C_S_AXI_ADDR_WIDTH'(drain_tag[19:10]) << LAYER_SHIFT) + (C_S_AXI_ADDR_WIDTH'(drain_tag[9:0]) << ROW_SHIFT);
    assign M_axi_awid = '0;
    assign M_axi_awlen = 8'(C_S_AXI_BURST_LEN - 1);
    assign M_axi_awsize = AWSIZE_8B;
    assign M_axi_awburst = BURST_INCR;
    assign M_axi_awlock = 1'b0;
    assign M_axi_awcache = AWCACHE;
    assign M_axi_awprot = '0;
    assign M_axi_awqos = '0;
    assign M_axi_wstrb = '1;
    assign M_axi_arid = '0;
    assign M_axi_araddr = '0;
    assign M_axi_arlen = '0;
    assign M_axi_arsize = '0;
    assign M_axi_arburst = '0;
    assign M_axi_arlock = 1'b0;
    assign M_axi_arcache = '0;
    assign M_axi_arprot = '0;
    assign M_axi_arqos = '0;
    assign M_axi_arvalid = 1'b0;
    assign M_axi_rready = 1'b0;
    assign unused_ok = ^{M_axi_bid, M_axi_arready, M_axi_rid, M_axi_rdata, M_axi_rresp, M_axi_rlast, M_axi_rvalid, output_layer_1_data};
endmodule

// File: doc/output_layer_writer.md
Name: output_layer_writer

Overview:
Write-side counterpart of the input layer streamer. It accepts a byte stream of output-layer pixels with a valid/ready handshake and packs each row into a 64-byte ping-pong buffer. Each completed row goes to DDR3 as one 8-beat AXI4 INCR write burst. It sits between the convolution datapath and the AXI interconnect, and uses the same DDR3 layout as the input layers: each layer is 4 KB aligned and each row is 64-byte aligned.

Parameters:
C_S_AXI_ID_WIDTH, 3, AXI ID width
C_S_AXI_ADDR_WIDTH, 32, AXI address width
C_S_AXI_DATA_WIDTH, 64, AXI data width (fixed at 64 for this block)
C_S_AXI_BURST_LEN, 8, beats per row burst (64 bytes / 8 bytes per beat)
STREAM_DATA_WIDTH, 8, one pixel byte per stream transfer

Ports:
clk  in  1  single clock for all logic
reset  in  1  synchronous, active-high reset
axi_address  in  32  base address of output layer 0
no_of_output_layers  in  10  layer count, 1..1023
output_layer_row_size  in  10  rows per layer, 1..64
output_layer_col_size  in  10  columns per row, 1..64
start  in  1  one-cycle pulse; samples config and begins
done  out  1  one-cycle pulse after the final B response
wr_error  out  1  sticky; set by any bresp != 0, cleared by start
output_layer_1_data  in  8  pixel byte
output_layer_1_valid  in  1  pixel valid
output_layer_1_rdy  out  1  block can accept a pixel
M_axi_aw*  out  various  awid=0, awlen=7, awsize=3, awburst=1, awlock=0, awcache=4'b0011, awprot=0, awqos=0, awaddr, awvalid; awready in
M_axi_w*  out  various  wdata[63:0], wstrb=8'hFF, wlast, wvalid; wready in
M_axi_b*  in  various  bid, bresp, bvalid; bready out
M_axi_ar*/r*  out/in  various  read channel tied off: arvalid=0, rready=0, other outputs 0

Behaviour:
- Reset values: done=0, wr_error=0, output_layer_1_rdy=0, awvalid=0, wvalid=0, wlast=0, bready=0. All counters are 0 and both buffers are empty.
- Reset mid-operation: all state clears the next cycle. Outstanding AXI transactions are abandoned; system-level recovery is outside this block.
- start is ignored while busy. On start, the config is latched, wr_error is cleared and the block becomes busy.
- Stream order: for each row r, for each layer l, columns 0..col_size-1. This matches the input-side iteration.
- Packer:
  - A transfer occurs when valid & rdy.
  - Column c writes byte lane c%8 of word c/8 in the fill buffer (little-endian).
  - rdy = busy & fill buffer not full.
- End of row, i.e. a transfer at c = col_size-1:
  - Remaining lanes and words up to 64 bytes are zero.
  - The buffer is marked full with tag (l, r).
  - The fill pointer toggles to the other buffer.
  - The column counter wraps to 0 and l increments; when l wraps to 0, r increments.
- When both buffers are full, rdy=0.
- Writer FSM:
  - IDLE -> AW when the drain buffer is full.
  - AW: awvalid=1, awaddr = axi_address + {l,12'b0} + {r,6'b0}, truncated to 32 bits. Stay until awready, then go to W.
  - W: wvalid=1, beats 0..7 from the drain buffer. The beat index advances only on wvalid&wready; wlast=1 on beat 7. After the beat-7 handshake, go to B.
  - B: bready=1 until bvalid. If bresp != 0, set wr_error. Release the drain buffer, toggle the drain pointer, return to IDLE.
- wvalid is never asserted before the AW handshake for the same burst.
- Latency: last row byte accepted at cycle T -> buffer full at T+1 -> awvalid at T+2 if the writer is IDLE.
- Simultaneous events: a buffer release in B and a fill completion in the same cycle are both honoured. rdy is recomputed from registered full flags and may stay low one extra cycle.
- done pulses one cycle after the B response for row row_size-1, layer no_of_output_layers-1. busy then drops.
- Counters are 10 bits; beat index is 3 bits; lane index is 3 bits.

Decomposition:
- Shared package output_layer_pkg:
  - AXI constants: AWSIZE_8B=3, BURST_INCR=1, AWCACHE=4'b0011, BEATS_PER_ROW=8.
  - Address shifts: ROW_SHIFT=6, LAYER_SHIFT=12.
  - Writer FSM state encoding: IDLE/AW/W/B.
- Sub-module row_pack_buffer: two 8x64-bit buffers with full flags, fill/drain pointers, byte-lane write port and beat read port. The top level holds the counters, address generation and writer FSM.

Test Plan:
1. layers=1, rows=1, cols=8, bytes 0x01..0x08, axi_address=0x01000000 -> one AW (addr 0x01000000, awlen 7); beat0 = 0x0807060504030201; beats 1..7 = 0; wlast only on beat 7; done after bvalid.
2. layers=2, rows=2, cols=55 -> AW addrs base+0x000, +0x1000, +0x040, +0x1040 in that order; beat 6 lane 7 = 0x00; done once.
3. awready held low 20 cycles with continuous input, cols=8 -> rdy drops after the second row is buffered; once awready rises, all bytes arrive intact and in order.
4. wready toggling 1/0 every cycle -> beat data unchanged; exactly 8 accepted beats; wlast coincides with the 8th.
5. bresp=2'b10 on the second burst of a 3-burst run -> wr_error=1 from then on; all 3 bursts issued; done pulses; the next start clears wr_error.
6. reset asserted during beat 3 of W -> next cycle awvalid=wvalid=bready=rdy=0; a new start rewrites from row 0, layer 0 at axi_address.
